dly_line_ctrl: RTL and testbench
================================

# dly_line_ctrl

Sequencing controller for a single-bit RAM-based delay line of `LENGTH` taps. It clears the line, gates its clock enable from an upstream sample strobe, and counts fill shifts. It tags every emerging bit as valid only once the line holds `LENGTH` real samples. It sits between the sync-signal front end and the delay line, and replaces free-running `clk_en`/`aclr` wiring.

## Interface
- `LENGTH`, 8192: delay-line depth in enabled shifts; must be ≥2.
- `CLR_CYCLES`, 2: number of cycles `dl_aclr` is held high per clear; must be ≥1.
- `WD_CYCLES`, 1024: watchdog limit. Only used with `DLY_CTRL_WATCHDOG_EN`.
- `CW`, derived as `$clog2(LENGTH+1)`: width of `fill_cnt`.

Ports:
- `clk`, in, 1: single clock.
- `aclr_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin operation. Honoured only in IDLE.
- `stop`, in, 1: return to IDLE.
- `flush`, in, 1: restart the fill. Honoured outside IDLE.
- `in_stb`, in, 1: upstream sample strobe.
- `in_bit`, in, 1: sample qualified by `in_stb`.
- `dl_aclr`, out, 1: delay-line clear.
- `dl_clk_en`, out, 1: delay-line shift enable.
- `dl_in`, out, 1: delay-line data in.
- `dl_out`, in, 1: delay-line shift-out.
- `out_bit`, out, 1: delayed sample.
- `out_valid`, out, 1: one-cycle qualifier for `out_bit`.
- `state`, out, 2: IDLE=0, CLEAR=1, FILL=2, RUN=3.
- `fill_cnt`, out, CW: shifts since the last clear, saturating at `LENGTH`.
- `wd_trip`, out, 1: one-cycle pulse when the watchdog fires.

## Operation
- **Delay-line contract:** after the k-th enabled shift since a clear, `dl_out` holds the bit from shift k−`LENGTH`, valid in the cycle after the shift edge.
- **IDLE:**
  - `start` moves to CLEAR.
  - `dl_clk_en`=0; strobes are dropped.
- **CLEAR:**
  - `dl_aclr`=1 for exactly `CLR_CYCLES` cycles, then move to FILL.
  - `fill_cnt` is set to 0; strobes are dropped.
- **FILL:**
  - Each `in_stb` is registered into `dl_clk_en`/`dl_in`.
  - `fill_cnt` increments on every cycle with `dl_clk_en`=1.
  - On the shift edge that makes `fill_cnt`=`LENGTH`, move to RUN.
  - Shifts issued in FILL never produce `out_valid`.
- **RUN:**
  - Strobes are registered as in FILL, and `fill_cnt` holds at `LENGTH`.
  - Each shift issued in RUN is tagged. One cycle after its shift, `dl_out` is captured into `out_bit` and `out_valid` pulses.
- **Priority,** evaluated every cycle: reset > `flush` > `stop` > `start` > `in_stb`.
  - `flush` in CLEAR/FILL/RUN moves to CLEAR, restarting the `CLR_CYCLES` count.
  - `stop` in CLEAR/FILL/RUN moves to IDLE. The line must be cleared again on the next `start`.
  - On `flush` or `stop`, the registered `dl_clk_en` and the capture tag are cancelled next cycle. No shift or `out_valid` results from strobes in flight.
  - An `in_stb` coincident with `flush`/`stop` is dropped.
- **Reset mid-operation:** all state is lost immediately and the block goes to IDLE.

## Timing
- **Reset values:**
  - `state`=IDLE; `fill_cnt`=0.
  - `dl_aclr`, `dl_clk_en`, `dl_in`, `out_bit`, `out_valid`, `wd_trip` all 0.
- **Outputs:** all registered; no combinational input-to-output paths.
- **Strobe path:**
  - `in_stb` in cycle t gives `dl_clk_en`=1 in t+1.
  - The shift occurs at the end of t+1.
  - For a RUN shift, `out_valid`=1 in t+3.
- **Control latency:**
  - `start` in cycle t: `state`=CLEAR and `dl_aclr`=1 from t+1 through t+`CLR_CYCLES`, `state`=FILL at t+`CLR_CYCLES`+1.
  - `stop`/`flush` take effect on `state` in the next cycle.
- **Throughput:** one strobe per cycle, sustained, in FILL and RUN.

## Configuration
- `DLY_CTRL_WATCHDOG_EN` defined:
  - In FILL/RUN, a counter runs on cycles without `in_stb` and resets on every `in_stb`.
  - When it reaches `WD_CYCLES`, `wd_trip` pulses one cycle and the state moves to CLEAR, behaving like `flush`.
  - The counter is cleared in IDLE/CLEAR.
- `DLY_CTRL_WATCHDOG_EN` undefined: no counter is built, `wd_trip` is tied 0, and the `WD_CYCLES` parameter is ignored.

## Test plan
Settings: `LENGTH`=4, `CLR_CYCLES`=2, `WD_CYCLES`=16.

1. **Start:** reset, then `start` pulse → `dl_aclr`=1 for 2 cycles, `state` 0→1→2, `fill_cnt`=0.
2. **Fill and run:** strobes on consecutive cycles with bits 1,0,1,1,0,0,1,0,1,1.
   - `fill_cnt` steps 1..4, `state`=3 after the 4th shift.
   - 6 `out_valid` pulses carry 1,0,1,1,0,0, each 3 cycles after strobes 5–10.
3. **Flush in RUN:** `flush` with coincident `in_stb` → strobe dropped, `dl_aclr`=1 for 2 cycles, `fill_cnt`=0. The next 4 strobes give no `out_valid`; the 5th does.
4. **Stop vs flush:** `stop`+`flush` in the same cycle in FILL → `state`=CLEAR. `stop` alone in RUN → `state`=IDLE, the in-flight strobe yields no shift, and `start` is required to resume.
5. **Watchdog:** in RUN with no strobes.
   - Macro defined: `wd_trip` pulses after 16 cycles and `state`=CLEAR.
   - Macro undefined: `wd_trip`=0 and `state`=RUN after 100 idle cycles.
6. **Async reset:** assert `aclr_n`=0 mid-FILL → all outputs 0 and `state`=IDLE immediately.

Source files
------------

// File: rtl/dly_line_ctrl.sv
// Sequencing controller for a single-bit RAM delay line: clear, strobe-gated shift enable, fill count, output tagging.
// Optional watchdog (idle-strobe timeout that forces a re-clear) is built when DLY_CTRL_WATCHDOG_EN is defined.
module dly_line_ctrl #(
    parameter int LENGTH     = 8192,
    parameter int CLR_CYCLES = 2,
    parameter int WD_CYCLES  = 1024,
    localparam int CW        = $clog2(LENGTH + 1)
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          start,
    input  logic          stop,
    input  logic          flush,
    input  logic          in_stb,
    input  logic          in_bit,
    output logic          dl_aclr,
    output logic          dl_clk_en,
    output logic          dl_in,
    input  logic          dl_out,
    output logic          out_bit,
    output logic          out_valid,
    output logic [1:0]    state,
    output logic [CW-1:0] fill_cnt,
    output logic          wd_trip
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLRW-1:0] CLR_LAST_C = CLRW'(CLR_CYCLES - 1);
    localparam logic [CLRW-1:0] CLR_ONE_C  = CLRW'(1'b1);
    localparam logic [CLRW-1:0] CLR_ZERO_C = {CLRW{1'b0}};
    localparam logic [CW-1:0]   LEN_M1_C   = CW'(LENGTH - 1);
    localparam logic [CW-1:0]   CNT_ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO_C = {CW{1'b0}};

    state_t          state_r;
    logic [CLRW-1:0] clr_cnt_r;
    logic [CW-1:0]   fill_cnt_r;
    logic            dl_aclr_r;
    logic            dl_clk_en_r;
    logic            dl_in_r;
    logic            tag_r;
    logic            out_bit_r;
    logic            out_valid_r;
    logic            wd_trip_r;
    logic            active_s;
    logic            wd_fire_s;

    assign active_s = (state_r == ST_FILL) || (state_r == ST_RUN);

`ifdef DLY_CTRL_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST_C = WDW'(WD_CYCLES - 1);
    localparam logic [WDW-1:0] WD_ONE_C  = WDW'(1'b1);
    logic [WDW-1:0] wd_cnt_r;

    // Counts consecutive strobe-less cycles while the line is being fed.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wd_cnt_r <= {WDW{1'b0}};
        end else if (!active_s || in_stb || flush || stop || wd_fire_s) begin
            wd_cnt_r <= {WDW{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_ONE_C;
        end
    end

    assign wd_fire_s = active_s && !in_stb && (wd_cnt_r == WD_LAST_C);
`else
    assign wd_fire_s = 1'b0;
`endif

    // Main sequencer: state, clear timing, shift enable, fill count and output capture.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= CLR_ZERO_C;
            fill_cnt_r  <= CNT_ZERO_C;
            dl_aclr_r   <= 1'b0;
            dl_clk_en_r <= 1'b0;
            dl_in_r     <= 1'b0;
            tag_r       <= 1'b0;
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            wd_trip_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            wd_trip_r   <= 1'b0;
            if ((flush && (state_r != ST_IDLE)) || (wd_fire_s && !stop)) begin
                // In-flight shift enable and capture tag are dropped; the line is re-cleared.
                state_r     <= ST_CLEAR;
                clr_cnt_r   <= CLR_LAST_C;
                fill_cnt_r  <= CNT_ZERO_C;
                dl_aclr_r   <= 1'b1;
                dl_clk_en_r <= 1'b0;
                tag_r       <= 1'b0;
                wd_trip_r   <= wd_fire_s && !flush;
            end else if (stop) begin
                state_r     <= ST_IDLE;
                dl_aclr_r   <= 1'b0;
                dl_clk_en_r <= 1'b0;
                tag_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        dl_clk_en_r <= 1'b0;
                        tag_r       <= 1'b0;
                        if (start) begin
                            state_r    <= ST_CLEAR;
                            clr_cnt_r  <= CLR_LAST_C;
                            fill_cnt_r <= CNT_ZERO_C;
                            dl_aclr_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            dl_aclr_r <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        dl_clk_en_r <= 1'b0;
                        tag_r       <= 1'b0;
                        fill_cnt_r  <= CNT_ZERO_C;
                        if (clr_cnt_r == CLR_ZERO_C) begin
                            state_r   <= ST_FILL;
                            dl_aclr_r <= 1'b0;
                        end else begin
                            clr_cnt_r <= clr_cnt_r - CLR_ONE_C;
                            dl_aclr_r <= 1'b1;
                        end
                    end
                    ST_FILL, ST_RUN: begin
                        dl_aclr_r   <= 1'b0;
                        dl_clk_en_r <= in_stb;
                        if (in_stb) begin
                            dl_in_r <= in_bit;
                        end else begin
                            dl_in_r <= dl_in_r;
                        end
                        // Only shifts issued once the line is full carry real delayed data.
                        tag_r       <= dl_clk_en_r && (state_r == ST_RUN);
                        out_valid_r <= tag_r;
                        if (tag_r) begin
                            out_bit_r <= dl_out;
                        end else begin
                            out_bit_r <= out_bit_r;
                        end
                        if ((state_r == ST_FILL) && dl_clk_en_r) begin
                            fill_cnt_r <= fill_cnt_r + CNT_ONE_C;
                            if (fill_cnt_r == LEN_M1_C) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_FILL;
                            end
                        end else begin
                            fill_cnt_r <= fill_cnt_r;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        dl_aclr_r   <= 1'b0;
                        dl_clk_en_r <= 1'b0;
                        tag_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state     = state_r;
    assign fill_cnt  = fill_cnt_r;
    assign dl_aclr   = dl_aclr_r;
    assign dl_clk_en = dl_clk_en_r;
    assign dl_in     = dl_in_r;
    assign out_bit   = out_bit_r;
    assign out_valid = out_valid_r;
    assign wd_trip   = wd_trip_r;

endmodule

// File: tb/tb_dly_line_ctrl.sv
// Self-checking bench for dly_line_ctrl with a behavioural 4-tap delay line and an output scoreboard.
module tb_dly_line_ctrl;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       aclr_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, flush = 1'b0, in_stb = 1'b0, in_bit = 1'b0;
    logic       dl_aclr, dl_clk_en, dl_in, dl_out, out_bit, out_valid, wd_trip;
    logic [1:0] state;
    logic [2:0] fill_cnt;

    dly_line_ctrl #(.LENGTH(LEN), .CLR_CYCLES(2), .WD_CYCLES(16)) dut (
        .clk(clk), .aclr_n(aclr_n), .start(start), .stop(stop), .flush(flush),
        .in_stb(in_stb), .in_bit(in_bit), .dl_aclr(dl_aclr), .dl_clk_en(dl_clk_en),
        .dl_in(dl_in), .dl_out(dl_out), .out_bit(out_bit), .out_valid(out_valid),
        .state(state), .fill_cnt(fill_cnt), .wd_trip(wd_trip)
    );

    always #5 clk = ~clk;

    // Behavioural delay line: after shift k, dl_out holds the bit of shift k-LEN.
    logic [LEN-1:0] line_r;
    logic           dl_out_r;
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            line_r <= '0; dl_out_r <= 1'b0;
        end else if (dl_aclr) begin
            line_r <= '0; dl_out_r <= 1'b0;
        end else if (dl_clk_en) begin
            dl_out_r <= line_r[LEN-1];
            line_r   <= {line_r[LEN-2:0], dl_in};
        end
    end
    assign dl_out = dl_out_r;

    typedef struct { logic b; int due; } exp_t;
    exp_t exp_q[$];
    logic hist[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accepted strobe: record it and predict the delayed bit it will expose.
    task automatic drive_stb(input logic b);
        in_stb = 1'b1;
        in_bit = b;
        hist.push_back(b);
        if (hist.size() > LEN) exp_q.push_back('{hist[hist.size()-1-LEN], cyc + 3});
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_bit", int'(out_bit), int'(e.b));
                check("out_valid_cycle", cyc, e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            check("missing_out_valid", 0, 1);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; flush = 1'b0; in_stb = 1'b0; in_bit = 1'b0;
    endtask

    typedef struct packed {
        logic       start, stop, flush, stb, b;
        logic [1:0] st;
        logic [2:0] fc;
        logic       aclr, en;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int seen;
        int trips;
        // start / fill / run: strobes 1,0,1,1,0,0,1,0,1,1
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 3'd1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd3, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_fill_cnt", int'(fill_cnt), 0);
        check("rst_outputs", int'({dl_aclr, dl_clk_en, dl_in, out_bit, out_valid, wd_trip}), 0);
        aclr_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; flush = vecs[i].flush;
            if (vecs[i].stb) drive_stb(vecs[i].b);
            else begin in_stb = 1'b0; in_bit = 1'b0; end
            if (vecs[i].start) hist.delete();
            step();
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            check($sformatf("vec%0d_fill_cnt", i), int'(fill_cnt), int'(vecs[i].fc));
            check($sformatf("vec%0d_dl_aclr", i), int'(dl_aclr), int'(vecs[i].aclr));
            check($sformatf("vec%0d_dl_clk_en", i), int'(dl_clk_en), int'(vecs[i].en));
        end
        idle_inputs();
        check("fill_run_drained", exp_q.size(), 0);

        // flush in RUN with a coincident strobe
        flush = 1'b1; in_stb = 1'b1; in_bit = 1'b1;
        step();
        idle_inputs();
        hist.delete();
        check("flush_state", int'(state), 1);
        check("flush_aclr", int'(dl_aclr), 1);
        check("flush_fill_cnt", int'(fill_cnt), 0);
        check("flush_stb_dropped", int'(dl_clk_en), 0);
        step();
        check("flush_aclr2", int'(dl_aclr), 1);
        step();
        check("flush_to_fill", int'(state), 2);
        check("flush_aclr_end", int'(dl_aclr), 0);
        for (int i = 0; i < 5; i++) begin
            drive_stb((i == 0 || i == 3) ? 1'b1 : 1'b0);
            step();
        end
        idle_inputs();
        repeat (5) step();
        check("flush_refill_drained", exp_q.size(), 0);

        // stop + flush in FILL: flush wins
        flush = 1'b1;
        step();
        idle_inputs();
        step(); step();
        check("pre_fill", int'(state), 2);
        stop = 1'b1; flush = 1'b1;
        step();
        idle_inputs();
        hist.delete();
        check("stop_flush_state", int'(state), 1);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            drive_stb(1'b1);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check("refill_run", int'(state), 3);
        // stop alone in RUN with a coincident strobe
        stop = 1'b1; in_stb = 1'b1; in_bit = 1'b1;
        step();
        idle_inputs();
        check("stop_state", int'(state), 0);
        check("stop_no_shift", int'(dl_clk_en), 0);
        in_stb = 1'b1;
        repeat (3) begin
            step();
            check("idle_stb_ignored", int'(dl_clk_en), 0);
            check("idle_stays", int'(state), 0);
        end
        idle_inputs();
        start = 1'b1;
        step();
        idle_inputs();
        hist.delete();
        check("restart_clear", int'(state), 1);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            drive_stb(1'b0);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check("wd_pre_run", int'(state), 3);

        // watchdog: no strobes in RUN
`ifdef DLY_CTRL_WATCHDOG_EN
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (wd_trip) begin
                seen = 1;
                check("wd_state_clear", int'(state), 1);
                break;
            end
        end
        check("wd_trip_seen", seen, 1);
        step();
        check("wd_trip_one_cycle", int'(wd_trip), 0);
`else
        trips = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (wd_trip) trips++;
        end
        check("wd_trip_never", trips, 0);
        check("wd_state_run", int'(state), 3);
`endif

        // async reset mid-FILL
        stop = 1'b1;
        step();
        idle_inputs();
        start = 1'b1;
        step();
        idle_inputs();
        hist.delete();
        step(); step();
        drive_stb(1'b1);
        step();
        drive_stb(1'b1);
        step();
        idle_inputs();
        #3;
        aclr_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_fill_cnt", int'(fill_cnt), 0);
        check("arst_outputs", int'({dl_aclr, dl_clk_en, dl_in, out_bit, out_valid, wd_trip}), 0);
        exp_q.delete();
        @(negedge clk);
        aclr_n = 1'b1;
        step();
        check("arst_release_idle", int'(state), 0);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
